slave_port: RTL and testbench

- Serial-bus responder: the slave-side endpoint of the single-bit master/slave bus driven by master_port.
- Deserialises request frames (mode, address, write data) from the bus.
- Issues one parallel valid/ready request per frame to a local device (memory or register file).
- For reads, serialises the device's response back onto the bus; for writes, returns a one-cycle acknowledge.

---
 rtl/slave_port_if.sv | 44 ++++
 rtl/slave_port.sv | 206 ++++++++++++++++++++
 tb/tb_slave_port.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_if.sv
// slave_port_if: groups the serial bus signals (master <-> slave_port) and the
// parallel device request/response signals (slave_port <-> local device).
//
// Parameters:
//   ADDR_WIDTH - local address bits carried in a frame
//   DATA_WIDTH - data bits per transfer
//
// Signals:
//   swdata, smode, mvalid - serial request bit, frame mode, frame-bit valid
//   srdata, svalid        - serial read-data bit and slave valid / write ack
//   daddr, dwdata, dmode  - device request address, write data, mode
//   dvalid, dready        - device request handshake
//   drdata, drvalid       - device read data and its single-cycle qualifier
//
// Modports:
//   slave  - the slave_port view
//   master - the environment view (bus master plus local device)
interface slave_port_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  swdata;
  logic                  smode;
  logic                  mvalid;
  logic                  srdata;
  logic                  svalid;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dmode;
  logic                  dvalid;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  drvalid;

  modport slave (
    input  swdata, smode, mvalid, dready, drdata, drvalid,
    output srdata, svalid, daddr, dwdata, dmode, dvalid
  );

  modport master (
    output swdata, smode, mvalid, dready, drdata, drvalid,
    input  srdata, svalid, daddr, dwdata, dmode, dvalid
  );
endinterface

// File: rtl/slave_port.sv
// slave_port: slave-side endpoint of the single-bit master/slave bus.
// Deserialises a request frame (mode, address, write data; LSB first), issues
// one valid/ready request to a local device, then either returns a one-cycle
// write acknowledge or serialises the device's read data back to the master.
//
// Parameters:
//   ADDR_WIDTH     - address bits per frame
//   DATA_WIDTH     - data bits per transfer
//   TIMEOUT_CYCLES - read-response timeout (only with SLAVE_PORT_TIMEOUT_EN)
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - slave_port_if.slave (serial bus and device request/response)
//
// Optional feature (macro SLAVE_PORT_TIMEOUT_EN): when defined, a read that
// sees no drvalid within TIMEOUT_CYCLES cycles of entering WAIT_RD returns
// all-ones data so the master never hangs. When undefined WAIT_RD waits forever.
module slave_port #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic         clk,
  input logic         rst,
  slave_port_if.slave bus
);

  localparam int unsigned MaxWidth = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntWidth = $clog2(MaxWidth + 1);
  localparam logic [CntWidth-1:0] AddrLast = CntWidth'(ADDR_WIDTH - 1);
  localparam logic [CntWidth-1:0] DataLast = CntWidth'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRxAddr,
    StRxData,
    StReq,
    StWaitRd,
    StTxData,
    StWrAck
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic srdata;
  logic svalid;
  logic dvalid;

`ifdef SLAVE_PORT_TIMEOUT_EN
  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

  logic [TmoWidth-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    srdata  = 1'b0;
    svalid  = 1'b0;
    dvalid  = 1'b0;
`ifdef SLAVE_PORT_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.mvalid) begin
          mode_d  = bus.smode;
          // Clear leftovers of an aborted frame while taking bit 0.
          addr_d  = ADDR_WIDTH'(bus.swdata);
          wdata_d = '0;
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = bus.smode ? StRxData : StReq;
          end else begin
            cnt_d   = CntWidth'(1);
            state_d = StRxAddr;
          end
        end
      end

      StRxAddr: begin
        if (!bus.mvalid) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_q | (ADDR_WIDTH'(bus.swdata) << cnt_q);
          if (cnt_q == AddrLast) begin
            cnt_d   = '0;
            state_d = mode_q ? StRxData : StReq;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end

      StRxData: begin
        if (!bus.mvalid) begin
          state_d = StIdle;
        end else begin
          wdata_d = wdata_q | (DATA_WIDTH'(bus.swdata) << cnt_q);
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = StReq;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end

      StReq: begin
        dvalid = 1'b1;
`ifdef SLAVE_PORT_TIMEOUT_EN
        tmo_d  = '0;
`endif
        if (bus.dready) begin
          state_d = mode_q ? StWrAck : StWaitRd;
        end
      end

      StWaitRd: begin
        if (bus.drvalid) begin
          rdata_d = bus.drdata;
          cnt_d   = '0;
          state_d = StTxData;
`ifdef SLAVE_PORT_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          rdata_d = '1;
          cnt_d   = '0;
          state_d = StTxData;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
`endif
        end
      end

      StTxData: begin
        svalid  = 1'b1;
        srdata  = rdata_q[0];
        rdata_d = rdata_q >> 1;
        if (cnt_q == DataLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StWrAck: begin
        svalid  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SLAVE_PORT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.srdata = srdata;
  assign bus.svalid = svalid;
  assign bus.dvalid = dvalid;
  assign bus.daddr  = addr_q;
  assign bus.dwdata = wdata_q;
  assign bus.dmode  = mode_q;

endmodule

// File: tb/tb_slave_port.sv
module tb_slave_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  slave_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  slave_port #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set before the call are consumed by the edge; outputs read after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic mode, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int abits);
    for (int i = 0; i < abits; i++) begin
      bus.mvalid = 1'b1;
      bus.smode  = (i == 0) ? mode : ~mode;
      bus.swdata = addr[i];
      step();
    end
    if (mode && abits == int'(AW)) begin
      for (int i = 0; i < int'(DW); i++) begin
        bus.mvalid = 1'b1;
        bus.smode  = ~mode;
        bus.swdata = data[i];
        step();
      end
    end
    bus.mvalid = 1'b0;
    bus.swdata = 1'b0;
    bus.smode  = 1'b0;
  endtask

  task automatic read_serial(input string tag, input logic [DW-1:0] exp);
    for (int i = 0; i < int'(DW); i++) begin
      check({tag, "_svalid"}, bus.svalid, 1);
      check({tag, "_srdata"}, bus.srdata, exp[i]);
      step();
    end
    check({tag, "_end"}, bus.svalid, 0);
  endtask

  task automatic handshake_read(input string tag, input logic [AW-1:0] addr);
    send_frame(1'b0, addr, '0, AW);
    check({tag, "_dvalid"}, bus.dvalid, 1);
    check({tag, "_dmode"}, bus.dmode, 0);
    check({tag, "_daddr"}, bus.daddr, 32'(addr));
    bus.dready = 1'b1;
    step();
    bus.dready = 1'b0;
    check({tag, "_dvalid_off"}, bus.dvalid, 0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.swdata = 1'b0;
    bus.smode  = 1'b0;
    bus.mvalid = 1'b0;
    bus.dready = 1'b0;
    bus.drdata = '0;
    bus.drvalid = 1'b0;
    step();
    step();

    // Reset state
    check("rst_svalid", bus.svalid, 0);
    check("rst_srdata", bus.srdata, 0);
    check("rst_dvalid", bus.dvalid, 0);
    check("rst_dmode", bus.dmode, 0);
    check("rst_daddr", bus.daddr, 0);
    check("rst_dwdata", bus.dwdata, 0);
    rst = 1'b0;
    step();

    // Write 0x5A3 / 0xC4, immediate dready
    send_frame(1'b1, 12'h5A3, 8'hC4, AW);
    check("wr_dvalid", bus.dvalid, 1);
    check("wr_daddr", bus.daddr, 32'h5A3);
    check("wr_dwdata", bus.dwdata, 32'hC4);
    check("wr_dmode", bus.dmode, 1);
    check("wr_no_svalid", bus.svalid, 0);
    bus.dready = 1'b1;
    step();
    bus.dready = 1'b0;
    check("wr_ack_svalid", bus.svalid, 1);
    check("wr_ack_srdata", bus.srdata, 0);
    check("wr_ack_dvalid", bus.dvalid, 0);
    step();
    check("wr_ack_once", bus.svalid, 0);

    // Read 0x0F0, device returns 0x3C
    handshake_read("rd", 12'h0F0);
    check("rd_wait_svalid", bus.svalid, 0);
    step();
    check("rd_wait2_svalid", bus.svalid, 0);
    bus.drvalid = 1'b1;
    bus.drdata  = 8'h3C;
    step();
    bus.drvalid = 1'b0;
    bus.drdata  = 8'h00;
    read_serial("rd", 8'h3C);

    // Backpressure: dready low for 5 cycles
    send_frame(1'b1, 12'h123, 8'h5E, AW);
    for (int i = 0; i < 5; i++) begin
      check("bp_dvalid", bus.dvalid, 1);
      check("bp_daddr", bus.daddr, 32'h123);
      check("bp_dwdata", bus.dwdata, 32'h5E);
      check("bp_dmode", bus.dmode, 1);
      check("bp_svalid", bus.svalid, 0);
      step();
    end
    bus.dready = 1'b1;
    step();
    bus.dready = 1'b0;
    check("bp_ack", bus.svalid, 1);
    check("bp_dvalid_off", bus.dvalid, 0);
    step();
    check("bp_ack_once", bus.svalid, 0);
    check("bp_one_hs", bus.dvalid, 0);

    // Abort after 7 address bits, then a normal read to 0x001
    send_frame(1'b0, 12'hFFF, '0, 7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_dvalid", bus.dvalid, 0);
      check("abort_svalid", bus.svalid, 0);
    end
    handshake_read("ab_rd", 12'h001);
    bus.drvalid = 1'b1;
    bus.drdata  = 8'hA5;
    step();
    bus.drvalid = 1'b0;
    read_serial("ab_rd", 8'hA5);

    // Reset after 3 read-data bits
    handshake_read("rst_rd", 12'h2AA);
    bus.drvalid = 1'b1;
    bus.drdata  = 8'h81;
    step();
    bus.drvalid = 1'b0;
    check("rst_rd_b0", bus.srdata, 1);
    step();
    check("rst_rd_b1", bus.srdata, 0);
    step();
    check("rst_rd_b2", bus.srdata, 0);
    check("rst_rd_sv", bus.svalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_svalid", bus.svalid, 0);
    check("midrst_srdata", bus.srdata, 0);
    check("midrst_dvalid", bus.dvalid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_quiet", bus.svalid, 0);
    end
    send_frame(1'b1, 12'h7FF, 8'hFF, AW);
    check("post_rst_daddr", bus.daddr, 32'h7FF);
    check("post_rst_dwdata", bus.dwdata, 32'hFF);
    bus.dready = 1'b1;
    step();
    bus.dready = 1'b0;
    check("post_rst_ack", bus.svalid, 1);
    step();
    check("post_rst_ack_once", bus.svalid, 0);

    // Stray drvalid in IDLE must be ignored
    bus.drvalid = 1'b1;
    bus.drdata  = 8'h11;
    step();
    bus.drvalid = 1'b0;
    check("stray_drvalid", bus.svalid, 0);

`ifdef SLAVE_PORT_TIMEOUT_EN
    // No drvalid: all-ones after 4 WAIT_RD cycles
    handshake_read("tmo", 12'h010);
    for (int i = 0; i < 4; i++) begin
      check("tmo_wait", bus.svalid, 0);
      step();
    end
    read_serial("tmo", 8'hFF);

    // drvalid on the timeout cycle carries the real data
    handshake_read("tmo_edge", 12'h020);
    for (int i = 0; i < 3; i++) begin
      step();
    end
    bus.drvalid = 1'b1;
    bus.drdata  = 8'h5A;
    step();
    bus.drvalid = 1'b0;
    read_serial("tmo_edge", 8'h5A);
`else
    // Without the timeout WAIT_RD waits indefinitely
    handshake_read("notmo", 12'h010);
    for (int i = 0; i < 12; i++) begin
      check("notmo_wait", bus.svalid, 0);
      step();
    end
    bus.drvalid = 1'b1;
    bus.drdata  = 8'h96;
    step();
    bus.drvalid = 1'b0;
    read_serial("notmo", 8'h96);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
